// File: rtl/ser2par_stream_if.sv
// ser2par_stream_if: serial beat input and buffered word output of ser2par_stream.
interface ser2par_stream_if #(
  parameter int LENGTH = 8,
  parameter int LANES  = 1
);
  logic              ivalid;
  logic [LANES-1:0]  idata;
  logic              ovalid;
  logic              oready;
  logic [LENGTH-1:0] odata;
  modport master (output ivalid, idata, oready, input ovalid, odata);
  modport slave  (input ivalid, idata, oready, output ovalid, odata);
endinterface

// File: rtl/ser2par_stream.sv
// ser2par_stream: multi-lane serial-to-parallel converter with runtime bit order,
// partial-word flush and a 2-entry valid/ready output buffer.
module ser2par_stream #(
  parameter int LENGTH = 8,
  parameter int LANES  = 1,
  localparam int NB    = LENGTH / LANES,
  localparam int BW    = $clog2(NB) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          direct,
  input  logic          flush,
  ser2par_stream_if.slave s,
  output logic [BW-1:0] beats,
  output logic          overflow
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t            state_q;
  logic [LENGTH-1:0] sr_q, head_q, tail_q, word_d;
  logic [BW-1:0]     beats_q;
  logic              dir_q, dir_d, ovalid_q, overflow_q, acc, push, pop;
  assign acc    = enable && s.ivalid && !flush;
  // bit order is frozen at the first beat of each word
  assign dir_d  = (beats_q == '0) ? direct : dir_q;
  assign word_d = dir_d ? {s.idata, sr_q[LENGTH-1:LANES]} : {sr_q[LENGTH-LANES-1:0], s.idata};
  assign push   = acc && beats_q == BW'(NB - 1);
  assign pop    = ovalid_q && s.oready;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      sr_q       <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      beats_q    <= '0;
      dir_q      <= 1'b0;
      ovalid_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (flush) begin
        beats_q    <= '0;
        sr_q       <= '0;
        overflow_q <= 1'b0;
      end else if (acc) begin
        sr_q    <= word_d;
        dir_q   <= dir_d;
        beats_q <= push ? '0 : beats_q + BW'(1);
      end
      case (state_q)
        EMPTY: if (push) begin
          head_q   <= word_d;
          state_q  <= ONE;
          ovalid_q <= 1'b1;
        end
        ONE: begin
          if (push && pop) head_q <= word_d;
          else if (push) begin
            tail_q  <= word_d;
            state_q <= FULL;
          end else if (pop) begin
            state_q  <= EMPTY;
            ovalid_q <= 1'b0;
          end
        end
        default: begin
          // a pop on the same edge frees the slot, so a completing word is never dropped then
          if (pop) begin
            head_q  <= tail_q;
            tail_q  <= push ? word_d : tail_q;
            state_q <= push ? FULL : ONE;
          end else if (push) overflow_q <= 1'b1;
        end
      endcase
    end
  end
  assign s.ovalid = ovalid_q;
  assign s.odata  = head_q;
  assign beats    = beats_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_ser2par_stream.sv
// tb_ser2par_stream: scoreboard bench for a 1-lane and a 2-lane ser2par_stream.
module tb_ser2par_stream;
  logic clk = 0, rst = 1, enable = 1, direct = 0, flush = 0;
  logic [3:0] beats1;
  logic [2:0] beats2;
  logic ovf1, ovf2;
  int passed = 0, total = 0;
  logic [7:0] q1[$], q2[$];
  ser2par_stream_if #(.LENGTH(8), .LANES(1)) if1();
  ser2par_stream_if #(.LENGTH(8), .LANES(2)) if2();
  ser2par_stream #(.LENGTH(8), .LANES(1)) u1 (.clock(clk), .reset(rst), .enable(enable), .direct(direct),
    .flush(flush), .s(if1), .beats(beats1), .overflow(ovf1));
  ser2par_stream #(.LENGTH(8), .LANES(2)) u2 (.clock(clk), .reset(rst), .enable(enable), .direct(direct),
    .flush(flush), .s(if2), .beats(beats2), .overflow(ovf2));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  task automatic pop_chk(input string n, input logic [7:0] a, inout logic [7:0] q[$]);
    if (q.size() == 0) begin
      total++;
      $display("FAIL %s: got %0h expected no word", n, a);
    end else chk(n, a, q.pop_front());
  endtask

  always @(negedge clk) if (!rst && if1.ovalid && if1.oready) pop_chk("odata1", if1.odata, q1);
  always @(negedge clk) if (!rst && if2.ovalid && if2.oready) pop_chk("odata2", if2.odata, q2);

  task automatic b1(input logic d);
    if1.ivalid = 1; if1.idata = d;
    @(posedge clk); #1;
    if1.ivalid = 0;
  endtask

  task automatic w1(input logic [7:0] w, input logic dir, input int lo, input int hi);
    direct = dir;
    for (int i = lo; i <= hi; i++) b1(dir ? w[i] : w[7-i]);
  endtask

  task automatic w2(input logic [7:0] w);
    direct = 0;
    for (int i = 0; i < 4; i++) begin
      if2.ivalid = 1; if2.idata = w[7-2*i -: 2];
      @(posedge clk); #1;
      if2.ivalid = 0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] stream;
    if1.ivalid = 0; if1.idata = 0; if1.oready = 1;
    if2.ivalid = 0; if2.idata = 0; if2.oready = 1;
    #1;
    chk("rst_ovalid", if1.ovalid, 0);
    chk("rst_odata", if1.odata, 0);
    chk("rst_beats", beats1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_ovalid2", if2.ovalid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // MSB first, 1 lane: 1,1,0,1,0,1,0,1 -> D5
    stream = 8'hD5;
    q1.push_back(8'hD5);
    for (int i = 0; i < 8; i++) begin
      b1(stream[7-i]);
      chk("beats_count", beats1, (i + 1) % 8);
    end
    chk("ovalid_after_word", if1.ovalid, 1);
    @(posedge clk); #1;
    chk("ovalid_one_cycle", if1.ovalid, 0);
    // LSB first with direct dropped on beat 4; next word MSB first
    stream = 8'hAB;
    q1.push_back(8'hAB);
    for (int i = 0; i < 8; i++) begin
      direct = (i < 3);
      b1(stream[i]);
    end
    q1.push_back(8'h3C);
    w1(8'h3C, 0, 0, 7);
    // 2 lanes, then back-to-back words
    q2.push_back(8'hD5);
    w2(8'hD5);
    chk("beats2_wrap", beats2, 0);
    chk("ovalid2", if2.ovalid, 1);
    q2.push_back(8'hA5); q2.push_back(8'h5A);
    w2(8'hA5); w2(8'h5A);
    repeat (3) @(posedge clk); #1;
    // stalled consumer: third word overflows
    if1.oready = 0;
    q1.push_back(8'h11); q1.push_back(8'h22);
    w1(8'h11, 0, 0, 7);
    w1(8'h22, 0, 0, 7);
    chk("ovf_not_yet", ovf1, 0);
    chk("odata_stable_a", if1.odata, 8'h11);
    w1(8'h33, 0, 0, 7);
    chk("ovf_set", ovf1, 1);
    chk("ovalid_stall", if1.ovalid, 1);
    chk("odata_stable_b", if1.odata, 8'h11);
    if1.oready = 1;
    repeat (4) @(posedge clk); #1;
    chk("drained", if1.ovalid, 0);
    // flush mid-word clears count and overflow
    w1(8'hFF, 0, 0, 4);
    chk("beats_before_flush", beats1, 5);
    flush = 1; if1.ivalid = 1; if1.idata = 1;
    @(posedge clk); #1;
    flush = 0; if1.ivalid = 0;
    chk("flush_beats", beats1, 0);
    chk("flush_ovf", ovf1, 0);
    q1.push_back(8'h96);
    w1(8'h96, 0, 0, 7);
    repeat (2) @(posedge clk); #1;
    // FULL with pop and push on the same edge
    if1.oready = 0;
    q1.push_back(8'h41); q1.push_back(8'h42); q1.push_back(8'h43);
    w1(8'h41, 0, 0, 7);
    w1(8'h42, 0, 0, 7);
    w1(8'h43, 0, 0, 6);
    if1.oready = 1;
    w1(8'h43, 0, 7, 7);
    chk("same_edge_no_ovf", ovf1, 0);
    repeat (5) @(posedge clk); #1;
    // enable low holds the partial word
    q1.push_back(8'h69);
    w1(8'h69, 0, 0, 3);
    enable = 0; if1.ivalid = 1; if1.idata = 1;
    repeat (3) @(posedge clk); #1;
    if1.ivalid = 0; enable = 1;
    chk("enable_hold", beats1, 4);
    w1(8'h69, 0, 4, 7);
    repeat (3) @(posedge clk); #1;
    // asynchronous reset with buffered words and a partial word
    if1.oready = 0;
    w1(8'h77, 0, 0, 7); w1(8'h78, 0, 0, 7); w1(8'h79, 0, 0, 7);
    w1(8'h12, 0, 0, 2);
    chk("ovf_before_reset", ovf1, 1);
    #2 rst = 1;
    #1;
    chk("async_ovalid", if1.ovalid, 0);
    chk("async_odata", if1.odata, 0);
    chk("async_beats", beats1, 0);
    chk("async_ovf", ovf1, 0);
    @(posedge clk); #1 rst = 0;
    if1.oready = 1;
    repeat (3) @(posedge clk); #1;
    chk("post_reset_empty", if1.ovalid, 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ser2par_stream.md
# ser2par_stream

Parametrised serial-to-parallel converter with multi-lane input, runtime bit order, partial-word flush and a 2-entry output buffer with valid/ready backpressure. It gathers `LENGTH`-bit words from a `LANES`-bit-wide serial stream and hands them to a downstream consumer that may stall. It sits in the Shift library alongside `ser2par`, as its successor for links wider than one bit or with a non-always-ready consumer.

## Interface
- `LENGTH`, 8, output word width in bits; must be a multiple of `LANES`, ≥ 2·`LANES`.
- `LANES`, 1, serial bits accepted per beat (1, 2, 4, 8 typical).
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  input-side gate; 0 = beats ignored, output side keeps running.
- `direct`  in  1  bit order: 0 = MSB first, 1 = LSB first; sampled on the first beat of each word.
- `flush`  in  1  discard the partial word and clear `overflow`.
- `ivalid`  in  1  `idata` carries a beat this cycle.
- `idata`  in  `LANES`  serial beat.
- `ovalid`  out  1  `odata` holds a completed word.
- `oready`  in  1  consumer accepts `odata` when `ovalid && oready`.
- `odata`  out  `LENGTH`  head word of the output buffer.
- `beats`  out  clog2(`LENGTH`/`LANES`)+1  beats collected in the current partial word.
- `overflow`  out  1  sticky: a completed word was dropped because the buffer was full.

## Operation
- Beat accepted when `enable && ivalid && !flush`; `beats` increments; no input backpressure exists.
- MSB first: shift register shifts left by `LANES`, `idata` enters at the low end; within a beat `idata[LANES-1]` is the earlier bit.
- LSB first: shift right by `LANES`, `idata` enters at the top; `idata[0]` is the earlier bit and ends at the lower index.
- `direct` is latched when `beats == 0` and a beat is accepted; changes mid-word take effect on the next word.
- Word complete on the beat that makes `beats == LENGTH/LANES`: word (including that beat) is pushed to the buffer, `beats` returns to 0 on the same edge, and the next word can start on the following cycle with no gap.
- Output buffer: 2-entry FIFO, states EMPTY / ONE / FULL.
  - push only: EMPTY→ONE, ONE→FULL.
  - pop only (`ovalid && oready`): FULL→ONE, ONE→EMPTY.
  - push and pop on the same edge: state unchanged, including in FULL (no drop).
  - push in FULL without pop: word dropped, `overflow` set, buffer contents unchanged.
- `flush`: `beats`→0, shift register→0, `overflow`→0; buffered words are kept and still delivered; any beat presented with `flush` is discarded.
- `enable` low: beats not counted, partial word held; resumes where it stopped.
- Reset values: `ovalid`=0, `odata`=0, `beats`=0, `overflow`=0; buffer EMPTY; latched order = MSB first.
- Reset mid-word or mid-stall: everything cleared immediately (asynchronous), partial and buffered words lost.

## Timing
- Latency: word-complete beat at edge N → `ovalid`=1 and `odata` valid after edge N (visible in cycle N+1).
- Sustained rate: one word per `LENGTH/LANES` cycles while `oready` stays high.
- `odata` stays stable while `ovalid && !oready`.
- `ovalid`, `odata`, `beats` and `overflow` are registered; no combinational path from `oready` or `idata` to any output.
- `ovalid` deasserts on the pop edge when the buffer goes to EMPTY.

## Test plan
- LENGTH=8, LANES=1, direct=0, `oready`=1, bits 1,1,0,1,0,1,0,1 → `odata`=8'hD5 with `ovalid` for one cycle, one cycle after the 8th beat; `beats` 1..7 then 0.
- Same stream, direct=1 → `odata`=8'hAB; `direct` toggled to 0 on beat 4 → word still 8'hAB, next word uses MSB first.
- LENGTH=8, LANES=2, direct=0, beats 2'b11,2'b01,2'b01,2'b01 → 8'hD5 after 4 beats; back-to-back words with no idle beat → two consecutive words, none lost.
- `oready`=0, push three words (8'h11, 8'h22, 8'h33) → `ovalid` stays 1, `odata`=8'h11 stable, `overflow`=1 on the third word's edge. Then `oready`=1 → 8'h11, 8'h22 delivered, 8'h33 never appears.
- Buffer FULL, `oready`=1 on the same edge a word completes → no overflow; 3 words delivered in order.
- 5 beats then `flush` → `beats`=0, `overflow` cleared, next 8 beats form a clean word. `enable`=0 for 3 cycles mid-word → word unchanged. `reset` pulsed mid-word → all outputs 0 asynchronously.
